// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI bus arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        OWNED  = 2'd0,
        BUSY   = 2'd1,
        SWITCH = 2'd2
    } arb_state_e;

    localparam logic SCLK_IDLE_DEFAULT = 1'b0;

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational round-robin pick: first requester after cur_i, wrapping; cur_i itself is checked last.
module rr_next_idx #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] nxt_c,
    output logic             valid_c
);

    int j;

    // Walk from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        nxt_c   = cur_i;
        valid_c = 1'b0;
        j       = 0;
        for (int k = int'(N); k >= 1; k--) begin
            j = int'(cur_i) + k;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            if (req_i[IDX_W'(j)]) begin
                nxt_c   = IDX_W'(j);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI pin set among NUM_MASTERS masters; ownership moves only while idle, behind a guard gap.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned SS_WIDTH     = 3,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter logic        CPOL         = SCLK_IDLE_DEFAULT,
    localparam int unsigned IDX_W       = idx_w(NUM_MASTERS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mode_auto_i,
    input  logic [IDX_W-1:0]                sel_i,
    input  logic [NUM_MASTERS-1:0]          req_i,
    input  logic                            clr_i,
    input  logic [NUM_MASTERS-1:0]          m_sclk_i,
    input  logic [NUM_MASTERS-1:0]          m_mosi_i,
    input  logic [NUM_MASTERS*SS_WIDTH-1:0] m_ss_n_i,
    output logic [NUM_MASTERS-1:0]          m_miso_o,
    output logic                            spi_sclk_o,
    output logic                            spi_mosi_o,
    output logic [SS_WIDTH-1:0]             spi_ss_n_o,
    input  logic                            spi_miso_i,
    output logic [NUM_MASTERS-1:0]          grant_o,
    output logic                            busy_o,
    output logic                            switching_o,
    output logic [NUM_MASTERS-1:0]          collision_o,
    output logic                            sel_err_o
);

    localparam int unsigned CNT_W = idx_w(GUARD_CYCLES);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       tgt_q, tgt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] collision_q, collision_d;
    logic                   sel_err_q, sel_err_d;
    logic                   busy_q, busy_d;
    logic                   switching_q, switching_d;

    logic [NUM_MASTERS-1:0] ss_low;
    logic [IDX_W-1:0]       rr_idx;
    logic                   rr_valid;
    logic                   sel_bad;
    logic [IDX_W-1:0]       target;
    logic                   owner_active;

    rr_next_idx #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (req_i),
        .cur_i   (owner_q),
        .nxt_c   (rr_idx),
        .valid_c (rr_valid)
    );

    // A master is active when any of its SS_n lines is low.
    always_comb begin
        ss_low = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            ss_low[i] = ~&m_ss_n_i[i*SS_WIDTH +: SS_WIDTH];
        end
    end

    assign owner_active = ss_low[owner_q];
    assign sel_bad      = ({1'b0, sel_i} >= (IDX_W+1)'(NUM_MASTERS));

    always_comb begin
        target = owner_q;
        if (mode_auto_i) begin
            if (rr_valid) begin
                target = rr_idx;
            end
        end else if (!sel_bad) begin
            target = sel_i;
        end
    end

    // Ownership FSM, stickies and registered status.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        collision_d = collision_q;
        sel_err_d   = sel_err_q;
        grant_d     = '0;

        unique case (state_q)
            OWNED: begin
                if (owner_active) begin
                    state_d = BUSY;
                end else if (target != owner_q) begin
                    state_d = SWITCH;
                    cnt_d   = CNT_W'(GUARD_CYCLES - 1);
                    tgt_d   = target;
                end
            end
            BUSY: begin
                if (!owner_active) begin
                    state_d = OWNED;
                end
            end
            SWITCH: begin
                if (cnt_q == '0) begin
                    owner_d = tgt_q;
                    state_d = OWNED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = OWNED;
        endcase

        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (ss_low[i] && ((IDX_W'(i) != owner_q) || (state_q == SWITCH))) begin
                collision_d[i] = 1'b1;
            end else if (clr_i) begin
                collision_d[i] = 1'b0;
            end
        end

        if (!mode_auto_i && sel_bad) begin
            sel_err_d = 1'b1;
        end else if (clr_i) begin
            sel_err_d = 1'b0;
        end

        grant_d[owner_d] = 1'b1;
        busy_d           = (state_d == BUSY);
        switching_d      = (state_d == SWITCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OWNED;
            owner_q     <= '0;
            tgt_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= NUM_MASTERS'(1);
            collision_q <= '0;
            sel_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            collision_q <= collision_d;
            sel_err_q   <= sel_err_d;
            busy_q      <= busy_d;
            switching_q <= switching_d;
        end
    end

    // Pin and MISO routing; the guard gap parks the bus idle.
    always_comb begin
        m_miso_o = '0;
        if (state_q == SWITCH) begin
            spi_sclk_o = CPOL;
            spi_mosi_o = 1'b0;
            spi_ss_n_o = '1;
        end else begin
            spi_sclk_o        = m_sclk_i[owner_q];
            spi_mosi_o        = m_mosi_i[owner_q];
            spi_ss_n_o        = m_ss_n_i[owner_q*SS_WIDTH +: SS_WIDTH];
            m_miso_o[owner_q] = spi_miso_i;
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign switching_o = switching_q;
    assign collision_o = collision_q;
    assign sel_err_o   = sel_err_q;

endmodule
